// File: rtl/stopwatch_counter.sv
// Stopwatch core: divides clk into centisecond ticks and counts MM:SS.cc in six
// BCD digits, with start/pause/resume, clear-while-stopped and lap freeze.
module stopwatch_counter #(
  parameter int TICK_DIV = 500000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] cs_tens,
  output logic [3:0] cs_ones,
  output logic       running,
  output logic       lap_hold
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  localparam logic [23:0] TICK_LAST = 24'(TICK_DIV - 1);

  state_t           state_reg;
  logic [23:0]      presc_reg;
  logic [5:0][3:0]  cnt_reg;
  logic [5:0][3:0]  snap_reg;
  logic [5:0][3:0]  cnt_next;
  logic [5:0][3:0]  disp;
  logic [5:0]       carry;
  logic             running_reg;
  logic             lap_hold_reg;
  logic             tick;

  assign tick     = (state_reg == RUN) && (presc_reg == TICK_LAST);
  assign carry[0] = tick;

  // Digit 0 is cs_ones, digit 5 is min_tens; the tens of seconds/minutes roll at 5.
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_digit
      localparam logic [3:0] LIM = (gi == 3 || gi == 5) ? 4'd5 : 4'd9;
      logic at_lim;
      assign at_lim       = (cnt_reg[gi] == LIM);
      assign cnt_next[gi] = !carry[gi] ? cnt_reg[gi] :
                            (at_lim ? 4'd0 : cnt_reg[gi] + 4'd1);
      if (gi < 5) begin : g_carry
        assign carry[gi+1] = carry[gi] & at_lim;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      presc_reg    <= '0;
      cnt_reg      <= '0;
      snap_reg     <= '0;
      running_reg  <= 1'b0;
      lap_hold_reg <= 1'b0;
    end else begin
      // Counting uses the pre-edge state, so a pausing edge still counts.
      if (state_reg == RUN) begin
        presc_reg <= tick ? 24'd0 : presc_reg + 24'd1;
        cnt_reg   <= cnt_next;
      end
      case (state_reg)
        IDLE: begin
          if (start_stop) begin
            state_reg   <= RUN;
            running_reg <= 1'b1;
          end
        end
        RUN: begin
          if (start_stop) begin
            state_reg   <= PAUSE;
            running_reg <= 1'b0;
          end
          if (lap) begin
            lap_hold_reg <= !lap_hold_reg;
            if (!lap_hold_reg) snap_reg <= cnt_reg;
          end
        end
        PAUSE: begin
          if (clear) begin
            state_reg    <= IDLE;
            presc_reg    <= '0;
            cnt_reg      <= '0;
            snap_reg     <= '0;
            lap_hold_reg <= 1'b0;
          end else begin
            if (start_stop) begin
              state_reg   <= RUN;
              running_reg <= 1'b1;
            end
            if (lap) lap_hold_reg <= 1'b0;
          end
        end
        default: begin
          state_reg   <= IDLE;
          running_reg <= 1'b0;
        end
      endcase
    end
  end

  assign disp     = lap_hold_reg ? snap_reg : cnt_reg;
  assign cs_ones  = disp[0];
  assign cs_tens  = disp[1];
  assign sec_ones = disp[2];
  assign sec_tens = disp[3];
  assign min_ones = disp[4];
  assign min_tens = disp[5];
  assign running  = running_reg;
  assign lap_hold = lap_hold_reg;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter with TICK_DIV=4; digits are compared as
// one packed BCD word {min_tens..cs_ones}, so 24'h000123 means 00:01.23.
module tb_stopwatch_counter;

  logic       clk;
  logic       reset_n;
  logic       start_stop;
  logic       clear;
  logic       lap;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones;
  logic       running;
  logic       lap_hold;

  int checks = 0;
  int errors = 0;

  stopwatch_counter #(.TICK_DIV(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_stop (start_stop),
    .clear      (clear),
    .lap        (lap),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .cs_tens    (cs_tens),
    .cs_ones    (cs_ones),
    .running    (running),
    .lap_hold   (lap_hold)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [23:0] disp;
  assign disp = {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1; step(1); start_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(1); clear = 1'b0;
  endtask

  task automatic pulse_lap();
    lap = 1'b1; step(1); lap = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    step(2);
    chk("reset_disp", 32'(disp), 32'h0);
    chk("reset_running", 32'(running), 32'd0);
    chk("reset_lap_hold", 32'(lap_hold), 32'd0);
    reset_n = 1'b1;

    // Idle: nothing moves, clear and lap are ignored.
    for (int i = 0; i < 10; i++) begin
      step(10);
      chk("idle_disp", 32'(disp), 32'h0);
    end
    chk("idle_running", 32'(running), 32'd0);
    pulse_clear();
    chk("idle_clear_disp", 32'(disp), 32'h0);
    pulse_lap();
    chk("idle_lap_hold", 32'(lap_hold), 32'd0);

    // Start at edge 0; ticks land on edges 4, 8, ...
    pulse_ss();
    chk("start_running", 32'(running), 32'd1);
    chk("start_disp", 32'(disp), 32'h0);
    step(3);
    chk("edge3_disp", 32'(disp), 32'h0);
    step(1);
    chk("tick1_disp", 32'(disp), 32'h000001);
    step(4);
    chk("tick2_disp", 32'(disp), 32'h000002);
    step(152);
    chk("tick40_disp", 32'(disp), 32'h000040);
    step(23836);
    chk("tick5999_disp", 32'(disp), 32'h005999);
    step(4);
    chk("tick6000_disp", 32'(disp), 32'h010000);
    chk("tick6000_running", 32'(running), 32'd1);

    // Pause then clear.
    pulse_ss();
    chk("pause_running", 32'(running), 32'd0);
    step(20);
    chk("pause_hold_disp", 32'(disp), 32'h010000);
    pulse_clear();
    chk("clear_disp", 32'(disp), 32'h0);
    chk("clear_running", 32'(running), 32'd0);

    // Pause with prescaler at 2, resume continues the partial tick.
    pulse_ss();
    step(29);
    chk("pre_pause_disp", 32'(disp), 32'h000007);
    pulse_ss();
    chk("pause2_running", 32'(running), 32'd0);
    step(50);
    chk("pause2_disp", 32'(disp), 32'h000007);
    pulse_ss();
    chk("resume_running", 32'(running), 32'd1);
    step(1);
    chk("resume_plus1_disp", 32'(disp), 32'h000007);
    step(1);
    chk("resume_plus2_disp", 32'(disp), 32'h000008);
    pulse_ss();
    start_stop = 1'b1; clear = 1'b1; step(1); start_stop = 1'b0; clear = 1'b0;
    chk("clr_ss_running", 32'(running), 32'd0);
    chk("clr_ss_disp", 32'(disp), 32'h0);
    step(8);
    chk("clr_ss_idle_disp", 32'(disp), 32'h0);

    // Lap: start at edge s, freeze at 00:01.23, release at 00:04.23.
    pulse_ss();
    step(492);
    chk("lap_live_disp", 32'(disp), 32'h000123);
    pulse_lap();
    chk("lap_set_hold", 32'(lap_hold), 32'd1);
    chk("lap_set_disp", 32'(disp), 32'h000123);
    step(1199);
    chk("lap_frozen_disp", 32'(disp), 32'h000123);
    pulse_lap();
    chk("lap_release_hold", 32'(lap_hold), 32'd0);
    chk("lap_release_disp", 32'(disp), 32'h000423);
    step(2);
    pulse_lap();
    chk("lap_tick_edge_hold", 32'(lap_hold), 32'd1);
    chk("lap_tick_edge_disp", 32'(disp), 32'h000423);
    pulse_lap();
    chk("lap_tick_edge_live", 32'(disp), 32'h000424);

    // Async reset mid-run with the display frozen.
    step(10);
    pulse_lap();
    chk("prereset_hold", 32'(lap_hold), 32'd1);
    #3 reset_n = 1'b0;
    #2;
    chk("async_reset_disp", 32'(disp), 32'h0);
    chk("async_reset_running", 32'(running), 32'd0);
    chk("async_reset_hold", 32'(lap_hold), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    step(12);
    chk("post_reset_idle_disp", 32'(disp), 32'h0);
    chk("post_reset_running", 32'(running), 32'd0);
    pulse_ss();
    step(3);
    chk("post_reset_edge3", 32'(disp), 32'h0);
    step(1);
    chk("post_reset_tick1", 32'(disp), 32'h000001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
